// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the processor memory-port arbiter.
// Bus command encoding and tag-owner encoding used by the arbiter and its tag table.
package mem_bus_arbiter_pkg;

  localparam int MEM_NUM_TAGS     = 16;
  localparam int MEM_TAG_W        = 4;
  localparam int MEM_MAX_D_STREAK = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    OWN_NONE = 2'h0,
    OWN_I    = 2'h1,
    OWN_D    = 2'h2
  } MEM_OWNER_t;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Owner table for outstanding memory load tags: one allocate port, one free/lookup port,
// combinational pre-edge lookup and per-side in-flight counters that mirror the table contents.
module mem_bus_arbiter_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = MEM_NUM_TAGS,
  parameter int TAG_W    = MEM_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [TAG_W-1:0] alloc_tag,
  input  MEM_OWNER_t       alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output MEM_OWNER_t       lookup_owner,
  output logic             alloc_conflict,
  output logic [TAG_W-1:0] i_count,
  output logic [TAG_W-1:0] d_count
);

  MEM_OWNER_t       owner_q [NUM_TAGS];
  MEM_OWNER_t       owner_d [NUM_TAGS];
  logic [TAG_W-1:0] i_count_q, i_count_d;
  logic [TAG_W-1:0] d_count_q, d_count_d;
  MEM_OWNER_t       alloc_prev;
  logic             free_valid;
  logic             freed_same;

  always_comb begin
    lookup_owner   = owner_q[lookup_tag];
    alloc_prev     = owner_q[alloc_tag];
    free_valid     = (lookup_tag != '0) && (lookup_owner != OWN_NONE);
    freed_same     = free_valid && (lookup_tag == alloc_tag);
    alloc_conflict = alloc_valid && (alloc_prev != OWN_NONE) && !freed_same;

    owner_d   = owner_q;
    i_count_d = i_count_q;
    d_count_d = d_count_q;

    if (free_valid) begin
      owner_d[lookup_tag] = OWN_NONE;
      if (lookup_owner == OWN_I) i_count_d = i_count_d - TAG_W'(1);
      if (lookup_owner == OWN_D) d_count_d = d_count_d - TAG_W'(1);
    end

    // An overwrite evicts the previous owner, so its counter must drop too.
    if (alloc_valid) begin
      if (alloc_conflict) begin
        if (alloc_prev == OWN_I) i_count_d = i_count_d - TAG_W'(1);
        if (alloc_prev == OWN_D) d_count_d = d_count_d - TAG_W'(1);
      end
      owner_d[alloc_tag] = alloc_owner;
      if (alloc_owner == OWN_I) i_count_d = i_count_d + TAG_W'(1);
      if (alloc_owner == OWN_D) d_count_d = d_count_d + TAG_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) owner_q[i] <= OWN_NONE;
      i_count_q <= '0;
      d_count_q <= '0;
    end else begin
      owner_q   <= owner_d;
      i_count_q <= i_count_d;
      d_count_q <= d_count_d;
    end
  end

  assign i_count = i_count_q;
  assign d_count = d_count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single processor memory port between the I-side and D-side controllers
// and routes accept/return tags back to whichever side owns them.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = MEM_NUM_TAGS,
  parameter int MAX_D_STREAK = MEM_MAX_D_STREAK
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           proc2Imem_command,
  input  logic [63:0]          proc2Imem_addr,
  input  logic [1:0]           proc2Dmem_command,
  input  logic [63:0]          proc2Dmem_addr,
  input  logic [63:0]          proc2Dmem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output logic [1:0]           proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  output logic [MEM_TAG_W-1:0] Imem2proc_response,
  output logic [MEM_TAG_W-1:0] Dmem2proc_response,
  output logic [MEM_TAG_W-1:0] Imem2proc_tag,
  output logic [MEM_TAG_W-1:0] Dmem2proc_tag,
  output logic [63:0]          mem2proc_data_out,
  output logic [MEM_TAG_W-1:0] I_outstanding,
  output logic [MEM_TAG_W-1:0] D_outstanding,
  output logic                 arb_error
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] d_streak_q, d_streak_d;
  logic          arb_error_q, arb_error_d;
  logic          i_req, d_req, grant_i, grant_d, accepted;
  logic [1:0]    grant_cmd;
  logic          alloc_valid;
  MEM_OWNER_t    alloc_owner;
  MEM_OWNER_t    lookup_owner;
  logic          alloc_conflict;

  always_comb begin
    i_req     = (proc2Imem_command != BUS_NONE);
    d_req     = (proc2Dmem_command != BUS_NONE);
    grant_i   = i_req && (!d_req || (d_streak_q == STREAK_MAX));
    grant_d   = d_req && !grant_i;
    grant_cmd = grant_i ? proc2Imem_command : (grant_d ? proc2Dmem_command : BUS_NONE);
    accepted  = reset && (grant_i || grant_d) && (mem2proc_response != '0);
    alloc_valid = accepted && (grant_cmd == BUS_LOAD);
    alloc_owner = grant_i ? OWN_I : OWN_D;
  end

  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Imem2proc_response = '0;
    Dmem2proc_response = '0;
    Imem2proc_tag      = '0;
    Dmem2proc_tag      = '0;
    if (reset) begin
      proc2mem_command = grant_cmd;
      if (grant_i) begin
        proc2mem_addr      = proc2Imem_addr;
        Imem2proc_response = mem2proc_response;
      end else if (grant_d) begin
        proc2mem_addr      = proc2Dmem_addr;
        Dmem2proc_response = mem2proc_response;
        if (proc2Dmem_command == BUS_STORE) proc2mem_data = proc2Dmem_data;
      end
      // Routing uses the pre-edge owner, so a same-cycle reallocation cannot steal the return.
      if (lookup_owner == OWN_I) Imem2proc_tag = mem2proc_tag;
      if (lookup_owner == OWN_D) Dmem2proc_tag = mem2proc_tag;
    end
  end

  always_comb begin
    d_streak_d = d_streak_q;
    if (!i_req) begin
      d_streak_d = '0;
    end else if (accepted && grant_i) begin
      d_streak_d = '0;
    end else if (accepted && grant_d && (d_streak_q != STREAK_MAX)) begin
      d_streak_d = d_streak_q + SW'(1);
    end

    arb_error_d = arb_error_q;
    if ((mem2proc_tag != '0) && (lookup_owner == OWN_NONE)) arb_error_d = 1'b1;
    if (alloc_conflict) arb_error_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      d_streak_q  <= '0;
      arb_error_q <= 1'b0;
    end else begin
      d_streak_q  <= d_streak_d;
      arb_error_q <= arb_error_d;
    end
  end

  mem_bus_arbiter_tag_table #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (MEM_TAG_W)
  ) u_tag_table (
    .clock          (clock),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_tag      (mem2proc_response),
    .alloc_owner    (alloc_owner),
    .lookup_tag     (mem2proc_tag),
    .lookup_owner   (lookup_owner),
    .alloc_conflict (alloc_conflict),
    .i_count        (I_outstanding),
    .d_count        (D_outstanding)
  );

  assign mem2proc_data_out = mem2proc_data;
  assign arb_error         = arb_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a per-cycle reference model pushes expected
// outputs into a queue and an independent monitor pops and compares them mid-cycle.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic [1:0]  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  Imem2proc_response;
  logic [3:0]  Dmem2proc_response;
  logic [3:0]  Imem2proc_tag;
  logic [3:0]  Dmem2proc_tag;
  logic [63:0] mem2proc_data_out;
  logic [3:0]  I_outstanding;
  logic [3:0]  D_outstanding;
  logic        arb_error;

  mem_bus_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .Imem2proc_response (Imem2proc_response),
    .Dmem2proc_response (Dmem2proc_response),
    .Imem2proc_tag      (Imem2proc_tag),
    .Dmem2proc_tag      (Dmem2proc_tag),
    .mem2proc_data_out  (mem2proc_data_out),
    .I_outstanding      (I_outstanding),
    .D_outstanding      (D_outstanding),
    .arb_error          (arb_error)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        chk_bus;
    logic        chk_reg;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] data_out;
    logic [3:0]  iresp;
    logic [3:0]  dresp;
    logic [3:0]  itag;
    logic [3:0]  dtag;
    logic [3:0]  iout;
    logic [3:0]  dout;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("proc2mem_command", 64'(proc2mem_command), 64'(e.cmd));
        if (e.chk_bus) begin
          check("proc2mem_addr", proc2mem_addr, e.addr);
          check("proc2mem_data", proc2mem_data, e.data);
        end
        check("Imem2proc_response", 64'(Imem2proc_response), 64'(e.iresp));
        check("Dmem2proc_response", 64'(Dmem2proc_response), 64'(e.dresp));
        check("Imem2proc_tag", 64'(Imem2proc_tag), 64'(e.itag));
        check("Dmem2proc_tag", 64'(Dmem2proc_tag), 64'(e.dtag));
        check("mem2proc_data_out", mem2proc_data_out, e.data_out);
        if (e.chk_reg) begin
          check("I_outstanding", 64'(I_outstanding), 64'(e.iout));
          check("D_outstanding", 64'(D_outstanding), 64'(e.dout));
          check("arb_error", 64'(arb_error), 64'(e.err));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Table as a plain array of owners (0 none, 1 I, 2 D); counts are derived by counting.
  int m_owner[16];
  int m_streak = 0;
  bit m_err    = 1'b0;
  bit m_known  = 1'b0;

  function automatic int count_owner(input int who);
    int n = 0;
    for (int t = 0; t < 16; t++) if (m_owner[t] == who) n++;
    return n;
  endfunction

  function automatic logic [3:0] pick_free();
    int list[$];
    for (int t = 1; t < 16; t++) if (m_owner[t] == 0) list.push_back(t);
    if (list.size() == 0) return 4'd0;
    return 4'(list[$urandom_range(0, list.size() - 1)]);
  endfunction

  function automatic logic [3:0] pick_owned();
    int list[$];
    for (int t = 1; t < 16; t++) if (m_owner[t] != 0) list.push_back(t);
    if (list.size() == 0) return 4'd0;
    return 4'(list[$urandom_range(0, list.size() - 1)]);
  endfunction

  task automatic model_step(input bit rst, input logic [1:0] ic, input logic [63:0] ia,
                            input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                            input logic [3:0] rsp, input logic [3:0] rt, input logic [63:0] md);
    exp_t e;
    bit   ireq, dreq, gi, gd, acc;
    int   old_rt;
    int   nxt[16];
    e          = '0;
    e.chk_reg  = m_known;
    e.iout     = 4'(count_owner(1));
    e.dout     = 4'(count_owner(2));
    e.err      = m_err;
    e.data_out = md;
    if (!rst) begin
      e.chk_bus = 1'b0;
      e.cmd     = BUS_NONE;
      exp_q.push_back(e);
      for (int t = 0; t < 16; t++) m_owner[t] = 0;
      m_streak = 0;
      m_err    = 1'b0;
      m_known  = 1'b1;
      return;
    end
    e.chk_bus = 1'b1;
    ireq = (ic != BUS_NONE);
    dreq = (dc != BUS_NONE);
    gi   = ireq && (!dreq || m_streak == 4);
    gd   = dreq && !gi;
    if (gi) begin
      e.cmd = ic; e.addr = ia; e.iresp = rsp;
    end else if (gd) begin
      e.cmd = dc; e.addr = da; e.dresp = rsp;
      if (dc == BUS_STORE) e.data = dd;
    end else begin
      e.cmd = BUS_NONE;
    end
    old_rt = (rt != 0) ? m_owner[rt] : 0;
    if (old_rt == 1) e.itag = rt;
    if (old_rt == 2) e.dtag = rt;
    exp_q.push_back(e);

    nxt = m_owner;
    if (rt != 0) begin
      if (old_rt == 0) m_err = 1'b1;
      else nxt[rt] = 0;
    end
    acc = (rsp != 0) && (gi || gd);
    if (acc && e.cmd == BUS_LOAD) begin
      if (m_owner[rsp] != 0 && !(rt == rsp && old_rt != 0)) m_err = 1'b1;
      nxt[rsp] = gi ? 1 : 2;
    end
    m_owner = nxt;
    if (!ireq) m_streak = 0;
    else if (acc && gi) m_streak = 0;
    else if (acc && gd && m_streak < 4) m_streak++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input logic [1:0] ic, input logic [63:0] ia,
                       input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                       input logic [3:0] rsp, input logic [3:0] rt);
    logic [63:0] md;
    @(posedge clock);
    #1;
    md                = {$urandom, $urandom};
    reset             = rst;
    proc2Imem_command = ic;
    proc2Imem_addr    = ia;
    proc2Dmem_command = dc;
    proc2Dmem_addr    = da;
    proc2Dmem_data    = dd;
    mem2proc_response = rsp;
    mem2proc_tag      = rt;
    mem2proc_data     = md;
    model_step(rst, ic, ia, dc, da, dd, rsp, rt, md);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, BUS_NONE, 64'd0, BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, BUS_NONE, 64'd0, BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [1:0]  ic, dc;
    logic [3:0]  rsp, rt;
    reset = 1'b0;
    proc2Imem_command = BUS_NONE; proc2Imem_addr = '0;
    proc2Dmem_command = BUS_NONE; proc2Dmem_addr = '0; proc2Dmem_data = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;

    // Reset held low for two cycles while both sides request.
    for (int i = 0; i < 2; i++)
      drive(1'b0, BUS_LOAD, 64'h1111, BUS_LOAD, 64'h2222, 64'h3333, 4'd4, 4'd0);

    // Lone I load accepted as tag 3, returned later.
    drive(1'b1, BUS_LOAD, 64'h100, BUS_NONE, 64'd0, 64'd0, 4'd3, 4'd0);
    idle(2);
    drive(1'b1, BUS_NONE, 64'd0, BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd3);
    idle(1);

    // Both request continuously, every grant accepted: D x4 then I.
    do_reset();
    for (int k = 0; k < 11; k++)
      drive(1'b1, BUS_LOAD, 64'h1000 + 64'(k), BUS_LOAD, 64'h2000 + 64'(k), 64'd0, pick_free(), 4'd0);
    idle(1);

    // Store accepted as tag 5 is never recorded; its "return" is an error.
    do_reset();
    drive(1'b1, BUS_NONE, 64'd0, BUS_STORE, 64'h200, 64'hDEAD, 4'd5, 4'd0);
    idle(1);
    drive(1'b1, BUS_NONE, 64'd0, BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd5);
    idle(1);

    // Same-cycle free (I) and reallocation (D) of tag 7.
    do_reset();
    drive(1'b1, BUS_LOAD, 64'h700, BUS_NONE, 64'd0, 64'd0, 4'd7, 4'd0);
    drive(1'b1, BUS_NONE, 64'd0, BUS_LOAD, 64'h710, 64'd0, 4'd7, 4'd7);
    idle(2);
    drive(1'b1, BUS_NONE, 64'd0, BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd7);
    idle(1);

    // Mid-flight reset with tags 2 (I) and 9 (D) outstanding.
    do_reset();
    drive(1'b1, BUS_LOAD, 64'h20, BUS_NONE, 64'd0, 64'd0, 4'd2, 4'd0);
    drive(1'b1, BUS_NONE, 64'd0, BUS_LOAD, 64'h90, 64'd0, 4'd9, 4'd0);
    idle(1);
    do_reset();
    drive(1'b1, BUS_NONE, 64'd0, BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd9);
    idle(1);

    // Randomised traffic with occasional rejects, stray tags and resets.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      ic = ($urandom_range(0, 99) < 65) ? BUS_LOAD : BUS_NONE;
      dc = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 99) < 25) rsp = 4'd0;
      else if ($urandom_range(0, 99) < 5) rsp = 4'($urandom_range(1, 15));
      else rsp = pick_free();
      if ($urandom_range(0, 99) < 40) rt = pick_owned();
      else if ($urandom_range(0, 99) < 3) rt = 4'($urandom_range(1, 15));
      else rt = 4'd0;
      drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, ic, {$urandom, $urandom},
            dc, {$urandom, $urandom}, {$urandom, $urandom}, rsp, rt);
    end
    idle(1);

    repeat (2) @(negedge clock);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
